fifo_write_arbiter: RTL
=======================

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NREQ, 4, number of requesters sharing the FIFO write port.
- DWIDTH, 8, data width per beat.
- MAXBURST, 8, maximum beats per grant.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- wclk  in  1  write-domain clock; all logic samples on its rising edge.
- wrst_n  in  1  reset, synchronous, active-low.
- req  in  NREQ  per-requester beat valid.
- last  in  NREQ  per-requester end-of-packet flag, qualified by req.
- wdata_in  in  NREQ*DWIDTH  requester i data at bits [i*DWIDTH +: DWIDTH].
- wfull  in  1  FIFO full flag from the FIFO write controller.
- ack  out  NREQ  combinational, one-hot; beat of requester i accepted this cycle.
- gnt  out  NREQ  registered, one-hot; current owner, all-zero when idle.
- wen  out  1  registered write enable to the FIFO.
- wdata  out  DWIDTH  registered write data to the FIFO.
- busy  out  1  registered; high while in BURST.
REQ-003 Clock and reset SHALL be one clock, wclk, and reset wrst_n, which is synchronous and active-low.

Function
REQ-004 The FSM SHALL have states IDLE and BURST, plus a rr_ptr register (0..NREQ-1) and a beat counter beat_cnt of width clog2(MAXBURST)+1.
REQ-005 In IDLE with req != 0, the block SHALL grant the first set req bit searching upward from rr_ptr with wrap: gnt <= onehot(winner), beat_cnt <= 0, state <= BURST.
REQ-006 In IDLE, ack and wen SHALL be 0; no beat is accepted in the arbitration cycle.
REQ-007 In BURST, ack[owner] SHALL be req[owner] & ~wfull, with all other ack bits 0.
REQ-008 On ack[owner], the next edge SHALL load wen <= 1 and wdata <= wdata_in[owner], and SHALL increment beat_cnt; in any other cycle, wen <= 0 and wdata holds.
REQ-009 Write latency SHALL be 1 cycle from ack to wen; throughput SHALL be 1 beat per cycle while wfull=0.
REQ-010 BURST SHALL exit to IDLE, setting gnt <= 0 and rr_ptr <= (owner+1) mod NREQ, on any of:
- an accepted beat with last[owner]=1;
- an accepted beat that makes beat_cnt reach MAXBURST;
- req[owner]=0 (abandon; no beat).
REQ-011 In BURST with wfull=1 and req[owner]=1, the block SHALL stay in BURST indefinitely with no ack, no timeout and no grant change.
REQ-012 Requests from non-owners during BURST SHALL be ignored until the next IDLE; there is always exactly one IDLE cycle between bursts.
REQ-013 If last[owner]=1 while wfull=1, the burst SHALL NOT end; it ends only on the accepted beat.
REQ-014 Simultaneous last and MAXBURST completion SHALL produce one release with a single rr_ptr update.
REQ-015 A single active requester SHALL be re-granted after the one IDLE cycle, with rr_ptr wrapping NREQ-1 -> 0.

Reset
REQ-016 With wrst_n=0 at a wclk edge, the block SHALL set state=IDLE, rr_ptr=0, beat_cnt=0, gnt=0, wen=0, wdata=0, busy=0; ack SHALL be 0 during and after reset.
REQ-017 Reset asserted mid-burst SHALL discard the pending grant; a beat acked in the reset cycle SHALL NOT produce wen.

Verification
REQ-018 req=4'b0110 from reset, wfull=0 -> gnt=4'b0010 one cycle later; after owner 1 releases, rr_ptr=2 and requester 2 is granted.
REQ-019 Requester 0 streams 3 beats 0xA1,0xA2,0xA3 with last on the third -> ack[0] for 3 cycles; wen high 3 cycles 1 cycle later with wdata A1,A2,A3; then IDLE.
REQ-020 Requester 3 holds req without last for 12 beats, MAXBURST=8 -> exactly 8 acks, release, 1 IDLE cycle, re-grant of requester 3 (rr_ptr 3->0, only req[3] set).
REQ-021 wfull=1 for 5 cycles mid-burst -> ack=0 and wen=0 for those cycles; gnt unchanged; streaming resumes the cycle wfull falls.
REQ-022 wrst_n pulsed low during beat 2 of a burst -> next cycle gnt=0, wen=0, busy=0, rr_ptr=0; with req=4'b1111, the first post-reset grant is 4'b0001.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter granting one requester at a time a burst of beats into a shared FIFO write port.
// A grant lasts until last, MAXBURST accepted beats, or the owner drops req; one IDLE cycle separates bursts.
module fifo_write_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned DWIDTH   = 8,
    parameter int unsigned MAXBURST = 8
) (
    input  logic                     wclk,
    input  logic                     wrst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          last,
    input  logic [NREQ*DWIDTH-1:0]   wdata_in,
    input  logic                     wfull,
    output logic [NREQ-1:0]          ack,
    output logic [NREQ-1:0]          gnt,
    output logic                     wen,
    output logic [DWIDTH-1:0]        wdata,
    output logic                     busy
);

    localparam int unsigned     PTRW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned     CNTW     = $clog2(MAXBURST) + 1;
    localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(MAXBURST);
    localparam logic [PTRW-1:0] PTR_LAST = PTRW'(NREQ - 1);
    localparam logic [NREQ-1:0] GNT_ONE  = NREQ'(1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state;
    logic [PTRW-1:0]   rr_ptr;
    logic [PTRW-1:0]   owner;
    logic [PTRW-1:0]   winner;
    logic [PTRW-1:0]   next_ptr;
    logic [CNTW-1:0]   beat_cnt;
    logic [CNTW-1:0]   cnt_inc;
    logic              any_req;
    logic              owner_req;
    logic              owner_last;
    logic              accept;
    logic              release_burst;
    logic [DWIDTH-1:0] owner_data;

    // First set request at or above rr_ptr, wrapping around.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            int unsigned idx;
            idx = (32'(rr_ptr) + i) % NREQ;
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                winner  = PTRW'(idx);
            end
        end
    end

    always_comb begin
        owner_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (owner == PTRW'(i)) begin
                owner_data = wdata_in[i*DWIDTH +: DWIDTH];
            end
        end
    end

    always_comb begin
        owner_req     = req[owner];
        owner_last    = last[owner];
        accept        = (state == BURST) && owner_req && !wfull;
        cnt_inc       = beat_cnt + 1'b1;
        // last and the MAXBURST limit share one release so rr_ptr advances exactly once.
        release_burst = (state == BURST) &&
                        (accept ? (owner_last || (cnt_inc == CNT_MAX)) : !owner_req);
        next_ptr      = (owner == PTR_LAST) ? '0 : owner + 1'b1;
        ack           = '0;
        if (accept && wrst_n) begin
            ack[owner] = 1'b1;
        end
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
            gnt      <= '0;
            wen      <= 1'b0;
            wdata    <= '0;
            busy     <= 1'b0;
        end else begin
            wen <= accept;
            if (accept) begin
                wdata    <= owner_data;
                beat_cnt <= cnt_inc;
            end
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state    <= BURST;
                        owner    <= winner;
                        gnt      <= GNT_ONE << winner;
                        beat_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                BURST: begin
                    if (release_burst) begin
                        state  <= IDLE;
                        gnt    <= '0;
                        busy   <= 1'b0;
                        rr_ptr <= next_ptr;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
